fp32_adder_dual_ctrl: RTL
=========================

# fp32_adder_dual_ctrl

Sequencer for the dual-lane fp32 accumulate pipeline: takes a tile job (base address, row count, pass count), accepts systolic-array result beats, issues accumulator-memory reads, drives `bias_mode` on the first pass, and tracks in-flight beats through the 4-stage adder so each sum is written back to the right row. It sits between the systolic-array output, the accumulator SRAM and the dual adder. Both lanes share one control stream. A scoreboard stalls input on read-after-write hazards when a pass is shorter than the pipeline depth.

## Interface
- `ADDR_W`, 8: accumulator row address width.
- `PASS_W`, 8: pass counter width.
- `RD_LAT`, 1: accumulator SRAM read latency, in cycles.
- `ADD_LAT`, 4: adder pipeline depth (compare, align, add, normalize).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cfg_start`  in  1: job start pulse; sampled only in IDLE.
- `cfg_base`  in  ADDR_W: first row address.
- `cfg_rows`  in  ADDR_W: rows per pass.
- `cfg_passes`  in  PASS_W: number of passes (K-dimension tiles).
- `in_valid`  in  1: systolic beat (both lanes) available.
- `in_ready`  out  1: beat accepted when `in_valid & in_ready`.
- `acc_rd_en`  out  1: accumulator read strobe.
- `acc_rd_addr`  out  ADDR_W: read row.
- `bias_mode`  out  1: adder selects bias instead of acc; aligned with the adder input cycle.
- `add_issue`  out  1: adder input operands valid this cycle.
- `acc_wr_en`  out  1: write adder result.
- `acc_wr_addr`  out  ADDR_W: write row.
- `busy`  out  1: job active.
- `done`  out  1: one-cycle pulse after the last write of the job.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `cfg_start` with `cfg_rows != 0` and `cfg_passes != 0`. Latch config; clear `row_cnt` and `pass_cnt`.
  - IDLE → DONE on `cfg_start` with `cfg_rows == 0` or `cfg_passes == 0`. No reads or writes are issued.
  - RUN → DRAIN on acceptance of the last beat (`row_cnt == rows-1` and `pass_cnt == passes-1`).
  - DRAIN → DONE when the in-flight scoreboard is empty.
  - DONE → IDLE unconditionally. `done` is high only in DONE.
- `cfg_start` outside IDLE is ignored.
- `busy` = state != IDLE.
- Beat acceptance, cycle t:
  - `acc_rd_en = 1`, `acc_rd_addr = base + row_cnt`, with wrap modulo 2^ADDR_W.
  - `row_cnt` increments. At rows-1 it wraps to 0 and `pass_cnt` increments.
  - The accept flag, address and `first = (pass_cnt == 0)` enter a valid/address/first shift register of depth RD_LAT + ADD_LAT.
- Adder issue:
  - `add_issue` is the accept flag delayed RD_LAT cycles.
  - `bias_mode` is the `first` flag delayed RD_LAT cycles. It is 0 when `add_issue` is 0.
- Write-back: `acc_wr_en` / `acc_wr_addr` are the delayed valid/address at depth RD_LAT + ADD_LAT.
- Hazard rule:
  - `in_ready = (state == RUN) & ~hit`.
  - `hit` is 1 when any valid scoreboard entry, including the one writing this cycle, holds address `base + row_cnt`.
  - The SRAM has no write-to-read forwarding, so the read waits until the cycle after that write.
- Bias-pass reads are still issued, so addressing stays uniform; the adder ignores the acc operand when `bias_mode` is set.

## Timing
- Reset values: `in_ready` 0, `acc_rd_en` 0, `acc_rd_addr` 0, `bias_mode` 0, `add_issue` 0, `acc_wr_en` 0, `acc_wr_addr` 0, `busy` 0, `done` 0. FSM is in IDLE; scoreboard and counters are cleared.
- `in_ready` may rise the cycle after `cfg_start` (first RUN cycle).
- Accept at t → `add_issue` at t+RD_LAT → `acc_wr_en` at t+RD_LAT+ADD_LAT (t+5 with defaults).
- Throughput: one beat per cycle when `rows >= RD_LAT + ADD_LAT + 1`.
- Short passes stall. With `rows = 2`, row 0 of pass 1 waits for the write of row 0 of pass 0; then `in_ready` rises.
- `done` fires exactly one cycle after the final `acc_wr_en`.
- `rst` asserted mid-job takes effect immediately: all in-flight beats are dropped and no write completes.
- `in_valid` with `in_ready` low is not consumed. No combinational path exists from `in_valid` to `in_ready`.

## Structure
- Shared package `fp32_adder_dual_pkg`:
  - FSM state enum.
  - Default values of `RD_LAT` and `ADD_LAT`, which must equal the adder's stage count.
- One sub-module, `fp32_adder_dual_ctrl_sb`:
  - Parameterized delay line of {valid, addr, first}.
  - Per-entry address-match output, reduced to `hit`.
  - Taps at RD_LAT and RD_LAT + ADD_LAT.

## Test plan
- `base = 0x10`, `rows = 8`, `passes = 2`, `in_valid` held high → 16 accepts on consecutive cycles; `bias_mode` high on the first 8 `add_issue` cycles; writes to 0x10..0x17 twice, each 5 cycles after its read; `done` one cycle after the 16th write.
- `rows = 2`, `passes = 3` → `in_ready` drops before each pass-boundary hazard read; every read of a row occurs after that row's prior write; 6 writes total; `done` asserted.
- `base = 0xFE`, `rows = 4`, `passes = 1` → addresses 0xFE, 0xFF, 0x00, 0x01 on both the read and write sides.
- `cfg_rows = 0` → `done` one cycle after start; no `acc_rd_en` or `acc_wr_en`. Second case: `cfg_start` during RUN → ignored; config unchanged.
- Random `in_valid` gaps with `rows = 5`, `passes = 4` → write count 20; write order equals read order; `bias_mode` high on exactly the first 5 issues.
- `rst` pulsed 2 cycles after the 3rd accept → all outputs 0 immediately; no `acc_wr_en` afterward; a new job runs cleanly.

Source files
------------

// File: rtl/fp32_adder_dual_pkg.sv
// Shared definitions for the dual-lane fp32 accumulate sequencer.
// The latency defaults must equal the read latency and stage count of the SRAM and adder.
package fp32_adder_dual_pkg;

  localparam int unsigned RD_LAT_DEF  = 1;
  localparam int unsigned ADD_LAT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp32_adder_dual_ctrl_sb.sv
// In-flight beat scoreboard: a delay line of {valid, addr, first} spanning the read
// and adder latency. It provides the issue and write-back taps and the RAW hit.
module fp32_adder_dual_ctrl_sb
  import fp32_adder_dual_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned RD_LAT  = RD_LAT_DEF,
  parameter int unsigned ADD_LAT = ADD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_first,
  input  logic [ADDR_W-1:0] i_cmp_addr,
  output logic              o_hit,
  output logic              o_issue,
  output logic              o_issue_first,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_pending
);

  localparam int unsigned DEPTH = RD_LAT + ADD_LAT;

  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  // The first flag is only consumed at the issue tap, so it is carried no further.
  logic [RD_LAT-1:0] r_first;

  logic [DEPTH-1:0]  w_match;
  logic              w_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_first <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_vld[0]   <= i_push;
      r_addr[0]  <= i_addr;
      r_first[0] <= i_push & i_first;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_first[i] <= r_first[i-1];
      end
    end
  end

  // The last stage is included: the SRAM cannot forward a same-cycle write to a read.
  always_comb begin
    w_match   = '0;
    w_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_match[i] = r_vld[i] && (r_addr[i] == i_cmp_addr);
    end
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      w_pending = w_pending | r_vld[i];
    end
  end

  assign o_hit         = |w_match;
  assign o_issue       = r_vld[RD_LAT-1];
  assign o_issue_first = r_first[RD_LAT-1];
  assign o_wr_en       = r_vld[DEPTH-1];
  assign o_wr_addr     = r_vld[DEPTH-1] ? r_addr[DEPTH-1] : '0;
  assign o_pending     = w_pending;

endmodule

// File: rtl/fp32_adder_dual_ctrl.sv
// Tile-job sequencer for the dual-lane fp32 accumulate pipeline: issues accumulator
// reads per accepted beat, drives bias on pass 0 and steers adder results back to their row.
module fp32_adder_dual_ctrl
  import fp32_adder_dual_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PASS_W  = 8,
  parameter int unsigned RD_LAT  = RD_LAT_DEF,
  parameter int unsigned ADD_LAT = ADD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_rows,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              acc_rd_en,
  output logic [ADDR_W-1:0] acc_rd_addr,
  output logic              bias_mode,
  output logic              add_issue,
  output logic              acc_wr_en,
  output logic [ADDR_W-1:0] acc_wr_addr,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_rows;
  logic [ADDR_W-1:0] r_row_cnt;
  logic [PASS_W-1:0] r_passes;
  logic [PASS_W-1:0] r_pass_cnt;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_hit;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last_row;
  logic              w_last_pass;
  logic              w_first;
  logic              w_issue;
  logic              w_issue_first;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_pending;

  assign w_rd_addr   = r_base + r_row_cnt;
  assign w_in_ready  = (r_state == ST_RUN) && !w_hit;
  assign w_accept    = in_valid && w_in_ready;
  assign w_last_row  = (r_row_cnt == r_rows - ADDR_W'(1));
  assign w_last_pass = (r_pass_cnt == r_passes - PASS_W'(1));
  assign w_first     = (r_pass_cnt == '0);

  fp32_adder_dual_ctrl_sb #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .ADD_LAT(ADD_LAT)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_accept),
    .i_addr       (w_rd_addr),
    .i_first      (w_first),
    .i_cmp_addr   (w_rd_addr),
    .o_hit        (w_hit),
    .o_issue      (w_issue),
    .o_issue_first(w_issue_first),
    .o_wr_en      (w_wr_en),
    .o_wr_addr    (w_wr_addr),
    .o_pending    (w_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_rows     <= '0;
      r_passes   <= '0;
      r_row_cnt  <= '0;
      r_pass_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (cfg_start) begin
            r_base     <= cfg_base;
            r_rows     <= cfg_rows;
            r_passes   <= cfg_passes;
            r_row_cnt  <= '0;
            r_pass_cnt <= '0;
            r_busy     <= 1'b1;
            if ((cfg_rows != '0) && (cfg_passes != '0)) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_last_row) begin
              r_row_cnt  <= '0;
              r_pass_cnt <= r_pass_cnt + PASS_W'(1);
              if (w_last_pass) begin
                r_state <= ST_DRAIN;
              end
            end else begin
              r_row_cnt <= r_row_cnt + ADDR_W'(1);
            end
          end
        end
        // Leaving when only the write-back stage is occupied puts done right after the last write.
        ST_DRAIN: begin
          if (!w_pending) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign acc_rd_en   = w_accept;
  assign acc_rd_addr = w_accept ? w_rd_addr : '0;
  assign add_issue   = w_issue;
  assign bias_mode   = w_issue && w_issue_first;
  assign acc_wr_en   = w_wr_en;
  assign acc_wr_addr = w_wr_addr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
